// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus of the instruction encoder.
// The slave side is the encoder; the master side is whoever feeds requests
// and owns the instruction memory.
interface instr_encoder_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clear_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [3:0]    op_sel_i;
  logic [4:0]    rs_i;
  logic [4:0]    rt_i;
  logic [4:0]    rd_i;
  logic [15:0]   imm_i;
  logic [25:0]   target_i;
  logic          imem_we_o;
  logic          imem_ready_i;
  logic [31:0]   imem_addr_o;
  logic [31:0]   imem_data_o;
  logic [LW-1:0] level_o;
  logic          err_o;

  modport master (
    output clear_i, req_valid_i, op_sel_i, rs_i, rt_i, rd_i, imm_i, target_i, imem_ready_i,
    input  req_ready_o, imem_we_o, imem_addr_o, imem_data_o, level_o, err_o
  );

  modport slave (
    input  clear_i, req_valid_i, op_sel_i, rs_i, rt_i, rd_i, imm_i, target_i, imem_ready_i,
    output req_ready_o, imem_we_o, imem_addr_o, imem_data_o, level_o, err_o
  );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder: turns symbolic requests into 32-bit MIPS words,
// queues them in a small FIFO and streams them into instruction memory at
// consecutive word addresses starting from BASE_ADDR.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  instr_encoder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  // op_sel values 13..15 have no encoding and only raise the sticky error.
  function automatic logic isLegal(input logic [3:0] opSel);
    isLegal = (opSel <= 4'd12);
  endfunction

  // shamt is always zero; JR forces rt and rd to zero.
  function automatic logic [31:0] encodeInstr(
    input logic [3:0]  opSel,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    case (opSel)
      4'd0:    encodeInstr = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      4'd1:    encodeInstr = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      4'd2:    encodeInstr = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      4'd3:    encodeInstr = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      4'd4:    encodeInstr = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      4'd5:    encodeInstr = {6'b000000, rs, 5'b00000, 5'b00000, 5'b00000, 6'b001000};
      4'd6:    encodeInstr = {6'b001000, rs, rt, imm};
      4'd7:    encodeInstr = {6'b001010, rs, rt, imm};
      4'd8:    encodeInstr = {6'b100011, rs, rt, imm};
      4'd9:    encodeInstr = {6'b101011, rs, rt, imm};
      4'd10:   encodeInstr = {6'b000100, rs, rt, imm};
      4'd11:   encodeInstr = {6'b000010, target};
      4'd12:   encodeInstr = {6'b000011, target};
      default: encodeInstr = 32'h0000_0000;
    endcase
  endfunction

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [LW-1:0] level;
  logic [LW-1:0] levelNext;
  logic [31:0]   addr;
  logic [31:0]   lastPop;
  logic          err;
  logic          acceptS;
  logic          pushS;
  logic          popS;
  logic          flushS;
  logic [31:0]   wordS;

  // Handshake decode: ready depends only on the registered level.
  always_comb begin
    flushS  = rst_i | bus.clear_i;
    acceptS = bus.req_valid_i & (level != LEVEL_FULL);
    wordS   = encodeInstr(bus.op_sel_i, bus.rs_i, bus.rt_i, bus.rd_i, bus.imm_i, bus.target_i);
    if (acceptS && isLegal(bus.op_sel_i)) begin
      pushS = 1'b1;
    end else begin
      pushS = 1'b0;
    end
    if ((level != '0) && bus.imem_ready_i) begin
      popS = 1'b1;
    end else begin
      popS = 1'b0;
    end
  end

  // Occupancy update: simultaneous push and pop leaves the level unchanged.
  always_comb begin
    levelNext = level;
    if (pushS && !popS) begin
      levelNext = level + LEVEL_ONE;
    end else if (!pushS && popS) begin
      levelNext = level - LEVEL_ONE;
    end else begin
      levelNext = level;
    end
  end

  // FIFO storage: contents are only ever read behind the valid level, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (pushS && !flushS) begin
      mem[wrPtr] <= wordS;
    end
  end

  // Pointers, level, write address, last popped word and sticky error.
  always_ff @(posedge clk_i) begin
    if (flushS) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      level   <= '0;
      addr    <= BASE_ADDR;
      lastPop <= 32'h0000_0000;
      err     <= 1'b0;
    end else begin
      level <= levelNext;
      if (pushS) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (popS) begin
        rdPtr   <= rdPtr + PW'(1);
        addr    <= addr + 32'd4;
        lastPop <= mem[rdPtr];
      end
      if (acceptS && !isLegal(bus.op_sel_i)) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.req_ready_o = (level != LEVEL_FULL);
  assign bus.imem_we_o   = (level != '0);
  assign bus.imem_addr_o = addr;
  assign bus.imem_data_o = (level != '0) ? mem[rdPtr] : lastPop;
  assign bus.level_o     = level;
  assign bus.err_o       = err;
endmodule
